// File: rtl/bcd2_pkg.sv
// Shared types, digit constants and WRAP_AT-to-BCD helper for the two-digit BCD counter.
// Optional build macro BCD2_EDGE_EN is consumed by bcd2_counter, not by this package.
package bcd2_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
    localparam bcd_digit_t BCD_ZERO      = 4'd0;

    // Splits a decimal value (0..99) into packed {tens, units} BCD.
    function automatic logic [7:0] wrap_to_bcd(input int unsigned value);
        bcd_digit_t tens;
        bcd_digit_t units;
        tens  = bcd_digit_t'(value / 10);
        units = bcd_digit_t'(value % 10);
        return {tens, units};
    endfunction

endpackage

// File: rtl/bcd2_counter_digit.sv
// Single decade counter stage: increments on inc, clears on clr, carries out of 9.
// Any nibble at or above 9 is treated as 9, so illegal codes recover to 0 on the next increment.
import bcd2_pkg::*;

module bcd_digit (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output bcd_digit_t digit,
    output logic       carry_out
);

    bcd_digit_t digit_reg;
    bcd_digit_t digit_next;

    always_comb begin
        digit_next = digit_reg;
        if (clr) begin
            digit_next = BCD_ZERO;
        end else if (inc) begin
            digit_next = (digit_reg >= BCD_MAX_DIGIT) ? BCD_ZERO : digit_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_reg <= BCD_ZERO;
        end else begin
            digit_reg <= digit_next;
        end
    end

    assign digit     = digit_reg;
    assign carry_out = inc && (digit_reg >= BCD_MAX_DIGIT);

endmodule

// File: rtl/bcd2_counter.sv
// Two-digit packed-BCD up-counter (00..WRAP_AT, then 00) advancing on qualified x activity.
// Define BCD2_EDGE_EN to count rising edges of x instead of cycles with x high.
import bcd2_pkg::*;

module bcd2_counter #(
    parameter int WRAP_AT = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    output logic [7:0] bcd2_out
);

    localparam logic [7:0] WRAP_BCD = wrap_to_bcd(WRAP_AT);

    logic       count_event;
    logic       wrap_clr;
    logic [2:0] carry_chain;
    bcd_digit_t digit_val [2];

`ifdef BCD2_EDGE_EN
    logic x_prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_prev_reg <= 1'b0;
        end else begin
            x_prev_reg <= x;
        end
    end

    assign count_event = x && !x_prev_reg;
`else
    assign count_event = x;
`endif

    assign carry_chain[0] = count_event;

    // A carry out of the tens digit only happens from 99 or an illegal tens code; treat it as a wrap.
    assign wrap_clr = (count_event && (bcd2_out == WRAP_BCD)) || carry_chain[2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk       (clk),
                .reset     (reset),
                .inc       (carry_chain[gi]),
                .clr       (wrap_clr),
                .digit     (digit_val[gi]),
                .carry_out (carry_chain[gi+1])
            );
        end
    endgenerate

    assign bcd2_out = {digit_val[1], digit_val[0]};

endmodule

// File: tb/tb_bcd2_counter.sv
// Self-checking bench for bcd2_counter (default WRAP_AT=99 plus a WRAP_AT=59 instance).
// Expectations follow BCD2_EDGE_EN when the bench is built with that macro.
module tb_bcd2_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       x = 1'b0;
    logic [7:0] bcd2_out;
    logic [7:0] bcd2_out_59;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       r;
        logic       xv;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    bcd2_counter #(.WRAP_AT(99)) dut (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .bcd2_out (bcd2_out)
    );

    bcd2_counter #(.WRAP_AT(59)) dut59 (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .bcd2_out (bcd2_out_59)
    );

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'((v % 100) / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Drive inputs, let one rising edge pass, then settle past it.
    task automatic step(input logic r, input logic xv);
        reset = r;
        x     = xv;
        @(posedge clk);
        #1;
    endtask

    // One count event in either build: one high cycle, followed by a low cycle.
    task automatic pulses(input int n);
        repeat (n) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
    endtask

    initial begin
        int level_cnt;
        int edge_cnt;
        logic prev_x;

        // Reset with x toggling, then release with x low.
        vecs.push_back('{1'b1, 1'b1, 8'h00});
        vecs.push_back('{1'b1, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 1'b0, 8'h00});
        // x held high for 12 cycles.
        for (int i = 1; i <= 12; i++) begin
`ifdef BCD2_EDGE_EN
            vecs.push_back('{1'b0, 1'b1, 8'h01});
`else
            vecs.push_back('{1'b0, 1'b1, to_bcd(i)});
`endif
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].xv);
            check($sformatf("vec%0d", i), bcd2_out, vecs[i].exp);
        end

        // Reset mid-count at 47 with x high, then resume.
        step(1'b1, 1'b0);
        pulses(47);
        check("count_to_47", bcd2_out, 8'h47);
        step(1'b1, 1'b1);
        check("reset_mid_count", bcd2_out, 8'h00);
        step(1'b0, 1'b1);
        check("resume_after_reset", bcd2_out, 8'h01);

        // Wrap points for WRAP_AT=99 and WRAP_AT=59.
        step(1'b1, 1'b0);
        pulses(59);
        check("w99_at_59", bcd2_out, 8'h59);
        check("w59_at_59", bcd2_out_59, 8'h59);
        pulses(1);
        check("w99_at_60", bcd2_out, 8'h60);
        check("w59_wrap", bcd2_out_59, 8'h00);
        pulses(39);
        check("w99_at_99", bcd2_out, 8'h99);
        check("w59_at_39", bcd2_out_59, 8'h39);
        pulses(1);
        check("w99_wrap", bcd2_out, 8'h00);
        check("w59_at_40", bcd2_out_59, 8'h40);

        // x held high for 20 cycles.
        step(1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b1);
`ifdef BCD2_EDGE_EN
        check("hold_high_20", bcd2_out, 8'h01);
`else
        check("hold_high_20", bcd2_out, 8'h20);
`endif

        // x toggling every 15 ns against the 10 ns clock for 2000 ns.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        level_cnt = 0;
        edge_cnt  = 0;
        prev_x    = 1'b0;
        @(posedge clk);
        fork
            begin
                #2;
                repeat (133) begin
                    x = ~x;
                    #15;
                end
            end
            begin
                repeat (200) begin
                    @(posedge clk);
                    if (x) level_cnt++;
                    if (x && !prev_x) edge_cnt++;
                    prev_x = x;
                end
            end
        join
        #1;
`ifdef BCD2_EDGE_EN
        check("toggle_2000ns", bcd2_out, to_bcd(edge_cnt));
`else
        check("toggle_2000ns", bcd2_out, to_bcd(level_cnt));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
